reg_file_write_demux: RTL

- 16 x 32-bit ARM register file (R0-R15) built around a 4-to-16 write-enable demultiplexer/decoder.
- Forms the write side of the datapath; the read side is the operand-select muxes.
- Sits between the writeback stage and the operand-fetch muxes.
- R15 doubles as the PC: it has a dedicated load port and a read offset, so fetch and branch logic share one storage element.

---
 rtl/reg_file_write_demux.sv | 96 +++++++++
 1 files changed

// File: rtl/reg_file_write_demux.sv
// 16-entry register file, write side built around a 4-to-16 enable decoder.
// R15 doubles as the PC: it has its own load port and reads back with a
// constant offset on the operand ports (ARM PC+8 semantics).

// One storage element; the enable and data arrive already resolved.
module reg_file_write_demux_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Reset clears; otherwise load when enabled, hold when not.
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

module reg_file_write_demux #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_READ_OFFSET = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [3:0]            wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  pc_ld,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [3:0]            ra,
    input  logic [3:0]            rb,
    output logic [DATA_WIDTH-1:0] rd_a,
    output logic [DATA_WIDTH-1:0] rd_b,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [15:0]           wr_onehot
);

    localparam int                  NUM_REGS = 16;
    localparam logic [DATA_WIDTH-1:0] PC_OFF = DATA_WIDTH'(PC_READ_OFFSET);

    logic [NUM_REGS-1:0]                 dec;
    logic [NUM_REGS-1:0]                 cell_en;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] cell_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [DATA_WIDTH-1:0]               pc_rd;

    // Write-address decode: one-hot when we is set, all-zero otherwise.
    always_comb begin
        dec = '0;
        if (we) dec[wa] = 1'b1;
    end

    // Per-register enable/data; the PC load only reaches R15 when the
    // general port is not also writing it (a general write to PC is a branch).
    always_comb begin
        cell_en = dec;
        cell_d  = {NUM_REGS{wd}};
        if (pc_ld && !dec[NUM_REGS-1]) begin
            cell_en[NUM_REGS-1] = 1'b1;
            cell_d[NUM_REGS-1]  = pc_in;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        reg_file_write_demux_cell #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .en   (cell_en[i]),
            .d    (cell_d[i]),
            .q    (regs[i])
        );
    end

    // Decode visibility register, one cycle behind we/wa.
    always_ff @(posedge clk) begin
        if (reset) wr_onehot <= '0;
        else       wr_onehot <= dec;
    end

    // Operand reads are combinational with no bypass; R15 reads carry the
    // pipeline offset (wraps modulo 2^DATA_WIDTH), fetch sees the raw PC.
    always_comb begin
        pc_rd  = regs[NUM_REGS-1] + PC_OFF;
        rd_a   = (ra == 4'hF) ? pc_rd : regs[ra];
        rd_b   = (rb == 4'hF) ? pc_rd : regs[rb];
        pc_out = regs[NUM_REGS-1];
    end

endmodule
